// File: rtl/pam_axil_pkg.sv
// pam_axil_pkg: shared response codes, write-channel states and byte-strobe merge for the PAM AXI-Lite register bank
package pam_axil_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {WR_COLLECT, WR_RESP} wr_state_t;
  // Widest supported bus is 64 bits; callers size-cast in and out.
  function automatic logic [63:0] strb_merge(input logic [63:0] old, input logic [63:0] data, input logic [7:0] strb);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) res[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : old[b*8 +: 8];
    return res;
  endfunction
endpackage

// File: rtl/pam_axil_addr_decode.sv
// pam_axil_addr_decode: byte address to register index, range and read-only flags
module pam_axil_addr_decode import pam_axil_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
)(
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      idx,
  output logic                  in_range,
  output logic                  is_ro
);
  localparam int ADDR_LSB = $clog2(DATA_WIDTH/8);
  localparam int PAD = 1 << IDX_W;
  localparam logic [PAD-1:0] RO_PAD = PAD'(RO_MASK);
  logic unused_lsb;
  assign unused_lsb = ^addr[ADDR_LSB-1:0];
  assign idx = addr[ADDR_LSB +: IDX_W];
  // In range iff the word address (index plus all bits above it) is below NUM_REGS.
  assign in_range = 32'(addr >> ADDR_LSB) < NUM_REGS;
  assign is_ro = RO_PAD[idx];
endmodule

// File: rtl/pam_axil_regbank.sv
// pam_axil_regbank: parametrised AXI4-Lite slave register bank with RO status and RW control registers
module pam_axil_regbank import pam_axil_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0
)(
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_d,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int STRB_W = DATA_WIDTH/8;
  localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  logic rst_done, aw_full, w_full;
  wr_state_t wr_state;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic [DATA_WIDTH-1:0] rw_q [NUM_REGS];
  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic aw_in, aw_ro, ar_in, ar_ro, wr_ok, aw_hs, w_hs, ar_hs;
  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};
  pam_axil_addr_decode #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK))
    u_aw_dec (.addr(aw_addr), .idx(aw_idx), .in_range(aw_in), .is_ro(aw_ro));
  pam_axil_addr_decode #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK))
    u_ar_dec (.addr(S_AXI_ARADDR), .idx(ar_idx), .in_range(ar_in), .is_ro(ar_ro));
  // rst_done keeps every READY low while reset is held.
  assign S_AXI_AWREADY = rst_done && !aw_full && !S_AXI_BVALID;
  assign S_AXI_WREADY = rst_done && !w_full && !S_AXI_BVALID;
  assign S_AXI_ARREADY = rst_done && !S_AXI_RVALID;
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign wr_ok = aw_in && !aw_ro;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? reg_d[i*DATA_WIDTH +: DATA_WIDTH] : rw_q[i];
  end
  // Flag the first clock after reset release so handshakes only open once out of reset.
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) rst_done <= 1'b0;
    else rst_done <= 1'b1;
  // Write path: independent AW/W holders, commit when both are full, then hold the response until BREADY.
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      wr_state <= WR_COLLECT;
      aw_full <= 1'b0;
      w_full <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP <= RESP_OKAY;
      wr_pulse <= '0;
      for (int k = 0; k < NUM_REGS; k++) rw_q[k] <= RESET_VAL[k*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      wr_pulse <= '0;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      case (wr_state)
        WR_COLLECT: if (aw_full && w_full) begin
          aw_full <= 1'b0;
          w_full <= 1'b0;
          S_AXI_BVALID <= 1'b1;
          S_AXI_BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
          wr_state <= WR_RESP;
          if (wr_ok) begin
            rw_q[aw_idx] <= DATA_WIDTH'(strb_merge(64'(rw_q[aw_idx]), 64'(w_data), 8'(w_strb)));
            wr_pulse[aw_idx] <= 1'b1;
          end
        end
        WR_RESP: if (S_AXI_BREADY) begin
          S_AXI_BVALID <= 1'b0;
          wr_state <= WR_COLLECT;
        end
        default: wr_state <= WR_COLLECT;
      endcase
    end
  // Read path: sample on accept (pre-write value on a same-cycle commit), hold RVALID until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA <= !ar_in ? '0 : ar_ro ? reg_d[ar_idx*DATA_WIDTH +: DATA_WIDTH] : rw_q[ar_idx];
      S_AXI_RRESP <= ar_in ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
endmodule

// File: tb/tb_pam_axil_regbank.sv
// tb_pam_axil_regbank: randomized self-checking bench against a register-array reference model
module tb_pam_axil_regbank;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 8;
  localparam logic [NR-1:0] RO = 8'b0000_0100;
  localparam logic [NR*DW-1:0] RV = (256'(32'h5A5A_0000) << 160) | (256'(1) << 32);
  logic ACLK, ARESETN;
  logic [AW-1:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0] S_AXI_AWPROT, S_AXI_ARPROT;
  logic S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BREADY;
  logic S_AXI_ARVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RREADY;
  logic [DW-1:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic [NR*DW-1:0] reg_q, reg_d;
  logic [NR-1:0] wr_pulse;
  logic [DW-1:0] rd_val [NR];
  logic [DW-1:0] model [NR];
  int exp_pulses [NR];
  int pulses [NR];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pam_axil_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(RV)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_q(reg_q), .reg_d(reg_d), .wr_pulse(wr_pulse)
  );

  initial begin
    ACLK = 0;
    forever #5 ACLK = ~ACLK;
  end

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(negedge ACLK)
    for (int i = 0; i < NR; i++) if (wr_pulse[i] === 1'b1) pulses[i] <= pulses[i] + 1;

  always_comb begin
    reg_d = '0;
    for (int i = 0; i < NR; i++) reg_d[i*DW +: DW] = rd_val[i];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic writable(input logic [AW-1:0] addr);
    int idx = int'(addr) / 4;
    return idx < NR && !RO[idx];
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] addr);
    int idx = int'(addr) / 4;
    if (idx >= NR) return '0;
    return RO[idx] ? rd_val[idx] : model[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = RV[i*DW +: DW];
  endtask

  task automatic check_image(input string tag);
    for (int i = 0; i < NR; i++) check(tag, reg_q[i*DW +: DW], RO[i] ? rd_val[i] : model[i]);
  endtask

  task automatic check_pulses();
    for (int i = 0; i < NR; i++) check("wr_pulse_count", pulses[i], exp_pulses[i]);
  endtask

  // mode 0: AW and W together; 1: W leads AW by 3 cycles; 2: AW leads W by 3 cycles. hold: cycles BREADY stays low.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb, input int mode, input int hold);
    int aw_c, w_c, b_c, last, idx;
    aw_c = -1; w_c = -1; b_c = -1;
    fork
      begin
        repeat (mode == 1 ? 3 : 0) @(negedge ACLK);
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1;
        for (int t = 0; t < 50; t++) begin
          if (S_AXI_AWREADY) begin @(posedge ACLK); @(negedge ACLK); aw_c = cyc; break; end
          @(negedge ACLK);
        end
        S_AXI_AWVALID = 0;
      end
      begin
        repeat (mode == 2 ? 3 : 0) @(negedge ACLK);
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1;
        for (int t = 0; t < 50; t++) begin
          if (S_AXI_WREADY) begin @(posedge ACLK); @(negedge ACLK); w_c = cyc; break; end
          @(negedge ACLK);
        end
        S_AXI_WVALID = 0;
      end
    join
    check("aw_handshake", aw_c >= 0, 1);
    check("w_handshake", w_c >= 0, 1);
    last = aw_c > w_c ? aw_c : w_c;
    for (int t = 0; t < 20; t++) begin
      if (S_AXI_BVALID) begin b_c = cyc; break; end
      @(negedge ACLK);
    end
    check("bvalid_latency", 64'(b_c - last), 64'(1));
    check("bresp", S_AXI_BRESP, writable(addr) ? 2'b00 : 2'b10);
    for (int h = 0; h < hold; h++) begin
      check("bvalid_hold_ready_low", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b100);
      @(negedge ACLK);
    end
    S_AXI_BREADY = 1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_BREADY = 0;
    check("bvalid_clear", S_AXI_BVALID, 0);
    if (writable(addr)) begin
      idx = int'(addr) / 4;
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      exp_pulses[idx]++;
    end
    check_pulses();
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] d, output logic [1:0] r);
    int ok = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1;
    for (int t = 0; t < 50; t++) begin
      if (S_AXI_ARREADY) begin @(posedge ACLK); @(negedge ACLK); ok = 1; break; end
      @(negedge ACLK);
    end
    S_AXI_ARVALID = 0;
    check("ar_handshake", ok, 1);
    check("rvalid_latency", S_AXI_RVALID, 1);
    d = S_AXI_RDATA; r = S_AXI_RRESP;
    S_AXI_RREADY = 1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_RREADY = 0;
    check("rvalid_clear", S_AXI_RVALID, 0);
  endtask

  task automatic read_check(input logic [AW-1:0] addr);
    logic [DW-1:0] d, e;
    logic [1:0] r;
    e = exp_rdata(addr);
    axi_read(addr, d, r);
    check("rdata", d, e);
    check("rresp", r, int'(addr) / 4 < NR ? 2'b00 : 2'b10);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready_valid"}, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID}, 5'b0);
    check({tag, "_resp_data"}, {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 36'b0);
    check({tag, "_wr_pulse"}, wr_pulse, 8'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d, old;
    logic [1:0] r;
    logic [AW-1:0] a;
    ARESETN = 0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    for (int i = 0; i < NR; i++) begin
      rd_val[i] = $urandom;
      exp_pulses[i] = 0;
      pulses[i] = 0;
    end
    rd_val[2] = 32'hCAFE_F00D;
    model_reset();
    repeat (3) @(negedge ACLK);
    check_reset_outputs("in_reset");
    check_image("reset_image");
    ARESETN = 1;
    @(negedge ACLK);
    read_check(8'h04);
    check("reset_reg1_const", model[1], 32'h1);
    read_check(8'h00);
    read_check(8'h14);
    // sequential writes 1..4, reg2 is read-only and must reject
    for (int i = 0; i < 4; i++) axi_write(8'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) read_check(8'(i * 4));
    check("ro_reg2_no_pulse", pulses[2], 0);
    check("ro_mirror", reg_q[2*DW +: DW], 32'hCAFE_F00D);
    // W before AW and AW before W
    axi_write(8'h10, 32'h1357_9BDF, 4'hF, 1, 0);
    axi_write(8'h14, 32'h2468_ACE0, 4'hF, 2, 0);
    read_check(8'h10);
    read_check(8'h14);
    // byte strobes
    axi_write(8'h18, 32'h1122_3344, 4'hF, 0, 0);
    axi_write(8'h18, 32'hAABB_CCDD, 4'b0101, 0, 0);
    axi_read(8'h18, d, r);
    check("wstrb_merge", d, 32'h11BB_33DD);
    check("wstrb_resp", r, 2'b00);
    // out-of-range write/read and unaligned low bits
    axi_write(8'h40, 32'hDEAD_BEEF, 4'hF, 0, 0);
    read_check(8'h40);
    read_check(8'h1B);
    // empty strobe still pulses without changing data
    axi_write(8'h1C, 32'hFFFF_FFFF, 4'h0, 0, 0);
    read_check(8'h1C);
    // BREADY held low
    axi_write(8'h0C, 32'h0BAD_F00D, 4'hF, 0, 5);
    read_check(8'h0C);
    // read accepted in the commit cycle sees the old value
    old = model[5];
    fork
      axi_write(8'h14, 32'h7777_8888, 4'hF, 0, 0);
      begin
        @(negedge ACLK);
        axi_read(8'h14, d, r);
      end
    join
    check("same_cycle_read_old", d, old);
    read_check(8'h14);
    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 2))
        0: begin
          a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
          axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        1: begin
          a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
          read_check(a);
        end
        default: begin
          rd_val[$urandom_range(0, NR - 1)] = $urandom;
          @(negedge ACLK);
          check_image("image_rand");
        end
      endcase
    end
    check_image("image_final");
    // asynchronous reset with both responses outstanding
    @(negedge ACLK);
    S_AXI_AWADDR = 8'h40; S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    S_AXI_ARADDR = 8'h04; S_AXI_ARVALID = 1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    @(negedge ACLK);
    check("pre_reset_valids", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP}, 4'b1110);
    check("pre_reset_rdata", S_AXI_RDATA, model[1]);
    #2 ARESETN = 0;
    #1;
    model_reset();
    check_reset_outputs("async_reset");
    check_image("async_reset_image");
    @(negedge ACLK);
    ARESETN = 1;
    @(negedge ACLK);
    read_check(8'h04);
    read_check(8'h0C);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
